// File: rtl/blink_pkg.sv
// Shared types and defaults for the blink line monitor.
//   blink_det_state_t : monitor state (IDLE, ARM, MEASURE, LOCKED, STUCK)
//   BLINK_CBITS_DFLT  : default width of the gap counter and period
package blink_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        MEASURE = 3'd2,
        LOCKED  = 3'd3,
        STUCK   = 3'd4
    } blink_det_state_t;

    localparam int BLINK_CBITS_DFLT = 26;

endpackage

// File: rtl/blink_gap_ctr.sv
// Saturating cycle counter that measures the distance since the last toggle.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart counting from zero on the next cycle
//   cnt       : cycles elapsed since the last clear, sticks at all-ones
//   interval  : cnt + 1, also sticking at all-ones (edge-to-edge distance)
module blink_gap_ctr #(
    parameter int CBITS = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CBITS-1:0] cnt,
    output logic [CBITS-1:0] interval
);

    logic [CBITS-1:0] gap_q;
    logic [CBITS-1:0] gap_d;
    logic             gap_full;

    assign gap_full = (gap_q == {CBITS{1'b1}});

    always_comb begin
        gap_d = gap_q;
        if (clr) begin
            gap_d = '0;
        end else if (!gap_full) begin
            gap_d = gap_q + CBITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

    assign cnt      = gap_q;
    assign interval = gap_full ? {CBITS{1'b1}} : gap_q + CBITS'(1);

endmodule

// File: rtl/blink_detect.sv
// Receive-side monitor for an LED blink line.
// Flags every toggle, measures the toggle interval, declares lock once
// LOCK_N consecutive intervals agree within TOL cycles, and flags a stuck
// line when no toggle arrives within max_gap cycles.
//   clk, rst : clock, asynchronous active-high reset
//   led_in   : monitored LED level, already synchronous to clk
//   max_gap  : stuck timeout in cycles, 0 disables the timeout
//   edge_o   : one-cycle pulse per detected toggle
//   period   : reference toggle interval in cycles
//   locked   : interval stable
//   stuck    : no toggle within max_gap cycles
// Build option: define BLINK_DETECT_ASSERT_EN to embed run-time assertions.
//
// state   | meaning
// IDLE    | waiting for the first toggle after reset
// ARM     | one toggle seen, next toggle gives the first interval
// MEASURE | reference period held, counting consistent intervals
// LOCKED  | LOCK_N consistent intervals seen
// STUCK   | no toggle within max_gap, waiting for the line to move
module blink_detect
    import blink_pkg::*;
#(
    parameter int CBITS  = BLINK_CBITS_DFLT,
    parameter int TOL    = 2,
    parameter int LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             led_in,
    input  logic [CBITS-1:0] max_gap,
    output logic             edge_o,
    output logic [CBITS-1:0] period,
    output logic             locked,
    output logic             stuck
);

    localparam logic [3:0]     LOCK_N_C = 4'(LOCK_N);
    localparam logic [CBITS:0] TOL_C    = (CBITS+1)'(TOL);

    blink_det_state_t  state_q, state_d;
    logic              led_q, led_d;
    logic [CBITS-1:0]  period_q, period_d;
    logic [3:0]        match_cnt_q, match_cnt_d;
    logic              edge_q, edge_d;
    logic              locked_q, locked_d;
    logic              stuck_q, stuck_d;

    logic              e;
    logic [CBITS-1:0]  gap_cnt;
    logic [CBITS-1:0]  interval;
    logic [CBITS:0]    diff;
    logic              is_match;
    logic [CBITS:0]    gap_plus1;
    logic              timeout;

    assign e = led_in ^ led_q;

    blink_gap_ctr #(
        .CBITS(CBITS)
    ) u_gap_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (e),
        .cnt      (gap_cnt),
        .interval (interval)
    );

    // Extra bit so the distance never wraps for large periods.
    always_comb begin
        if (interval >= period_q) begin
            diff = {1'b0, interval} - {1'b0, period_q};
        end else begin
            diff = {1'b0, period_q} - {1'b0, interval};
        end
    end

    assign is_match = (diff <= TOL_C);

    // Unsaturated gap+1: a pinned counter cannot re-fire the timeout.
    assign gap_plus1 = {1'b0, gap_cnt} + (CBITS+1)'(1);
    assign timeout   = (max_gap != '0) && (gap_plus1 == {1'b0, max_gap});

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        match_cnt_d = match_cnt_q;
        led_d       = led_in;
        edge_d      = e;

        case (state_q)
            IDLE: begin
                if (e) begin
                    state_d = ARM;
                end else if (timeout) begin
                    state_d     = STUCK;
                    match_cnt_d = '0;
                end
            end
            ARM: begin
                if (e) begin
                    period_d    = interval;
                    match_cnt_d = 4'd1;
                    state_d     = MEASURE;
                end else if (timeout) begin
                    state_d     = STUCK;
                    match_cnt_d = '0;
                end
            end
            MEASURE: begin
                if (e) begin
                    if (is_match) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_q + 4'd1 == LOCK_N_C) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        period_d    = interval;
                        match_cnt_d = 4'd1;
                    end
                end else if (timeout) begin
                    state_d     = STUCK;
                    match_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (e) begin
                    if (!is_match) begin
                        period_d    = interval;
                        match_cnt_d = 4'd1;
                        state_d     = MEASURE;
                    end
                end else if (timeout) begin
                    state_d     = STUCK;
                    match_cnt_d = '0;
                end
            end
            STUCK: begin
                if (e) begin
                    state_d = ARM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        locked_d = (state_d == LOCKED);
        stuck_d  = (state_d == STUCK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            led_q       <= 1'b0;
            period_q    <= '0;
            match_cnt_q <= '0;
            edge_q      <= 1'b0;
            locked_q    <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            period_q    <= period_d;
            match_cnt_q <= match_cnt_d;
            edge_q      <= edge_d;
            locked_q    <= locked_d;
            stuck_q     <= stuck_d;
        end
    end

    assign edge_o = edge_q;
    assign period = period_q;
    assign locked = locked_q;
    assign stuck  = stuck_q;

`ifdef BLINK_DETECT_ASSERT_EN
    a_lock_stuck_excl: assert property (@(posedge clk) disable iff (rst)
        !(locked && stuck));

    // Back-to-back pulses only when the line really toggled every cycle.
    a_edge_single: assert property (@(posedge clk) disable iff (rst)
        (edge_o && $past(edge_o)) |-> ($past(led_in, 1) != $past(led_in, 2)));

    a_stuck_on_time: assert property (@(posedge clk) disable iff (rst)
        ((state_q != STUCK) && !e && timeout) |=> stuck);

`ifdef FORMAL
    m_toggles_forever: assume property (@(posedge clk) !rst && s_eventually e);
    a_stuck_recovers: assert property (@(posedge clk) stuck |-> s_eventually !stuck);
`endif
`endif

endmodule
